// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle shared by the WB stage, the long-latency unit
// and the register file. The slave modport is the arbiter; master is the
// requester/consumer side.
interface regfile_write_arbiter_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_stall;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_data;
  logic                  lu_ready;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_rd_data;
  logic                  rf_src_lu;

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output wb_stall, lu_ready, rf_write_en, rf_rd, rf_rd_data, rf_src_lu
  );

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  wb_stall, lu_ready, rf_write_en, rf_rd, rf_rd_data, rf_src_lu
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and a
// long-latency unit. After MAX_WAIT consecutive lost cycles the LU is forced
// through for one cycle while WB stalls. Writes to x0 complete the handshake
// but are suppressed. Optional perf counters under macro WBARB_PERF_EN.
module regfile_write_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
`ifdef WBARB_PERF_EN
  ,
  output logic [31:0]            perf_conflicts,
  output logic [31:0]            perf_forced
`endif
);

  typedef enum logic [0:0] {StArb, StForceLu} state_e;

  localparam logic [3:0] WaitMax  = 4'(MAX_WAIT);
  localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

  state_e                state_q;
  logic [3:0]            wait_cnt_q;
  logic                  rf_write_en_q;
  logic [REG_ADDR_W-1:0] rf_rd_q;
  logic [XLEN-1:0]       rf_rd_data_q;
  logic                  rf_src_lu_q;

  logic                  grant_wb;
  logic                  grant_lu;
  logic                  lu_ready;
  logic                  wb_stall;
  logic                  lu_blocked;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [XLEN-1:0]       grant_data;

  // Grant decode and combinational handshake outputs.
  always_comb begin
    grant_wb = 1'b0;
    grant_lu = 1'b0;
    lu_ready = 1'b0;
    wb_stall = 1'b0;
    case (state_q)
      StForceLu: begin
        lu_ready = bus.lu_valid;
        wb_stall = bus.wb_valid;
        grant_lu = bus.lu_valid;
      end
      default: begin
        grant_wb = bus.wb_valid;
        grant_lu = bus.lu_valid & ~bus.wb_valid;
        lu_ready = bus.lu_valid & ~bus.wb_valid;
      end
    endcase
    lu_blocked = bus.lu_valid & ~lu_ready;
    grant_rd   = grant_lu ? bus.lu_rd : bus.wb_rd;
    grant_data = grant_lu ? bus.lu_data : bus.wb_data;
  end

  // FSM, starvation counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StArb;
      wait_cnt_q    <= '0;
      rf_write_en_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_rd_data_q  <= '0;
      rf_src_lu_q   <= 1'b0;
    end else begin
      case (state_q)
        StForceLu: state_q <= StArb;
        default: begin
          // Force fires after exactly MAX_WAIT blocked cycles.
          if (lu_blocked && (wait_cnt_q == WaitLast)) state_q <= StForceLu;
        end
      endcase

      if (!bus.lu_valid || lu_ready) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WaitMax) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end

      if (grant_wb || grant_lu) begin
        // x0 is hardwired: accept the request but write nothing.
        rf_write_en_q <= |grant_rd;
        rf_rd_q       <= grant_rd;
        rf_rd_data_q  <= (|grant_rd) ? grant_data : '0;
        rf_src_lu_q   <= grant_lu;
      end else begin
        rf_write_en_q <= 1'b0;
      end
    end
  end

  assign bus.lu_ready    = lu_ready;
  assign bus.wb_stall    = wb_stall;
  assign bus.rf_write_en = rf_write_en_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_rd_data  = rf_rd_data_q;
  assign bus.rf_src_lu   = rf_src_lu_q;

`ifdef WBARB_PERF_EN
  logic [31:0] perf_conflicts_q;
  logic [31:0] perf_forced_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts_q <= '0;
      perf_forced_q    <= '0;
    end else begin
      if (bus.wb_valid && bus.lu_valid) perf_conflicts_q <= perf_conflicts_q + 32'd1;
      if (state_q == StForceLu) perf_forced_q <= perf_forced_q + 32'd1;
    end
  end

  assign perf_conflicts = perf_conflicts_q;
  assign perf_forced    = perf_forced_q;
`endif

  // Requester protocol checks.
  a_lu_hold : assert property (@(posedge clk) disable iff (rst)
    bus.lu_valid && !lu_ready |=> bus.lu_valid);
  a_lu_stable : assert property (@(posedge clk) disable iff (rst)
    bus.lu_valid && !lu_ready |=> $stable(bus.lu_rd) && $stable(bus.lu_data));
  a_wb_stable : assert property (@(posedge clk) disable iff (rst)
    wb_stall |=> bus.wb_valid && $stable(bus.wb_rd) && $stable(bus.wb_data));
  a_force_has_lu : assert property (@(posedge clk) disable iff (rst)
    state_q == StForceLu |-> bus.lu_valid);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (MAX_WAIT = 4).
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  regfile_write_arbiter_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

`ifdef WBARB_PERF_EN
  logic [31:0] perf_conflicts;
  logic [31:0] perf_forced;
`endif

  regfile_write_arbiter #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .MAX_WAIT   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WBARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_forced    (perf_forced)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h11111111;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd8; bus.lu_data = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++; if (bus.rf_write_en !== 1'b0) begin err_cnt++;
        $display("FAIL reset_we: got %0h, expected 0", bus.rf_write_en); end
      vec_cnt++; if (bus.rf_rd !== 5'd0) begin err_cnt++;
        $display("FAIL reset_rd: got %0h, expected 0", bus.rf_rd); end
      vec_cnt++; if (bus.rf_rd_data !== 32'h0) begin err_cnt++;
        $display("FAIL reset_data: got %0h, expected 0", bus.rf_rd_data); end
      vec_cnt++; if (bus.lu_ready !== 1'b0) begin err_cnt++;
        $display("FAIL reset_lu_ready: got %0h, expected 0", bus.lu_ready); end
    end
    rst = 1'b0;
    bus.wb_valid = 1'b0;
    bus.lu_valid = 1'b0;
    tick();
    vec_cnt++; if (bus.rf_write_en !== 1'b0) begin err_cnt++;
      $display("FAIL idle_we: got %0h, expected 0", bus.rf_write_en); end
  endtask

  task automatic test_wb_only();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h12345678;
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b0) begin err_cnt++;
      $display("FAIL wb_only_stall: got %0h, expected 0", bus.wb_stall); end
    tick();
    bus.wb_valid = 1'b0;
    vec_cnt++; if (bus.rf_write_en !== 1'b1) begin err_cnt++;
      $display("FAIL wb_only_we: got %0h, expected 1", bus.rf_write_en); end
    vec_cnt++; if (bus.rf_rd !== 5'd1) begin err_cnt++;
      $display("FAIL wb_only_rd: got %0h, expected 1", bus.rf_rd); end
    vec_cnt++; if (bus.rf_rd_data !== 32'h12345678) begin err_cnt++;
      $display("FAIL wb_only_data: got %0h, expected 12345678", bus.rf_rd_data); end
    vec_cnt++; if (bus.rf_src_lu !== 1'b0) begin err_cnt++;
      $display("FAIL wb_only_src: got %0h, expected 0", bus.rf_src_lu); end
    tick();
    vec_cnt++; if (bus.rf_write_en !== 1'b0) begin err_cnt++;
      $display("FAIL no_grant_we: got %0h, expected 0", bus.rf_write_en); end
    vec_cnt++; if (bus.rf_rd !== 5'd1 || bus.rf_rd_data !== 32'h12345678) begin err_cnt++;
      $display("FAIL no_grant_hold: got %0h/%0h, expected 1/12345678",
               bus.rf_rd, bus.rf_rd_data); end
  endtask

  task automatic test_lu_only();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd2; bus.lu_data = 32'h87654321;
    #1;
    vec_cnt++; if (bus.lu_ready !== 1'b1) begin err_cnt++;
      $display("FAIL lu_only_ready: got %0h, expected 1", bus.lu_ready); end
    tick();
    bus.lu_valid = 1'b0;
    vec_cnt++; if (bus.rf_write_en !== 1'b1 || bus.rf_rd !== 5'd2) begin err_cnt++;
      $display("FAIL lu_only_we_rd: got %0h/%0h, expected 1/2", bus.rf_write_en, bus.rf_rd); end
    vec_cnt++; if (bus.rf_rd_data !== 32'h87654321) begin err_cnt++;
      $display("FAIL lu_only_data: got %0h, expected 87654321", bus.rf_rd_data); end
    vec_cnt++; if (bus.rf_src_lu !== 1'b1) begin err_cnt++;
      $display("FAIL lu_only_src: got %0h, expected 1", bus.rf_src_lu); end
  endtask

  task automatic test_x0();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEADBEEF;
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b0) begin err_cnt++;
      $display("FAIL x0_stall: got %0h, expected 0", bus.wb_stall); end
    tick();
    bus.wb_valid = 1'b0;
    vec_cnt++; if (bus.rf_write_en !== 1'b0) begin err_cnt++;
      $display("FAIL x0_we: got %0h, expected 0", bus.rf_write_en); end
    vec_cnt++; if (bus.rf_rd_data !== 32'h0) begin err_cnt++;
      $display("FAIL x0_data: got %0h, expected 0", bus.rf_rd_data); end
  endtask

  task automatic test_starvation();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'hCAFE0003;
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(10 + i); bus.wb_data = 32'hA0000000 + 32'(i);
      #1;
      vec_cnt++; if (bus.wb_stall !== 1'b0 || bus.lu_ready !== 1'b0) begin err_cnt++;
        $display("FAIL starve_block%0d: got stall/ready %0h/%0h, expected 0/0",
                 i, bus.wb_stall, bus.lu_ready); end
      tick();
      vec_cnt++; if (bus.rf_rd !== 5'(10 + i) || bus.rf_src_lu !== 1'b0) begin err_cnt++;
        $display("FAIL starve_wb%0d: got rd/src %0h/%0h, expected %0h/0",
                 i, bus.rf_rd, bus.rf_src_lu, 10 + i); end
    end
    bus.wb_rd = 5'd14; bus.wb_data = 32'hA0000004;
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b1 || bus.lu_ready !== 1'b1) begin err_cnt++;
      $display("FAIL starve_force: got stall/ready %0h/%0h, expected 1/1",
               bus.wb_stall, bus.lu_ready); end
    tick();
    bus.lu_valid = 1'b0;
    vec_cnt++; if (bus.rf_rd !== 5'd3 || bus.rf_src_lu !== 1'b1 ||
                   bus.rf_rd_data !== 32'hCAFE0003) begin err_cnt++;
      $display("FAIL starve_lu_write: got rd/src/data %0h/%0h/%0h, expected 3/1/cafe0003",
               bus.rf_rd, bus.rf_src_lu, bus.rf_rd_data); end
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b0) begin err_cnt++;
      $display("FAIL starve_unstall: got %0h, expected 0", bus.wb_stall); end
    tick();
    bus.wb_valid = 1'b0;
    vec_cnt++; if (bus.rf_rd !== 5'd14 || bus.rf_rd_data !== 32'hA0000004 ||
                   bus.rf_src_lu !== 1'b0) begin err_cnt++;
      $display("FAIL starve_held_wb: got rd/data/src %0h/%0h/%0h, expected e/a0000004/0",
               bus.rf_rd, bus.rf_rd_data, bus.rf_src_lu); end
    tick();
  endtask

  task automatic test_reset_mid_force();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'hCAFE0003;
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(10 + i); bus.wb_data = 32'hB0000000 + 32'(i);
      tick();
    end
    bus.wb_rd = 5'd14; bus.wb_data = 32'hB0000004;
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b1) begin err_cnt++;
      $display("FAIL mid_force_stall: got %0h, expected 1", bus.wb_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++; if (bus.rf_write_en !== 1'b0 || bus.rf_rd !== 5'd0 ||
                   bus.rf_src_lu !== 1'b0) begin err_cnt++;
      $display("FAIL mid_force_reset: got we/rd/src %0h/%0h/%0h, expected 0/0/0",
               bus.rf_write_en, bus.rf_rd, bus.rf_src_lu); end
    for (int i = 0; i < 4; i++) begin
      bus.wb_rd = 5'(20 + i); bus.wb_data = 32'hC0000000 + 32'(i);
      #1;
      vec_cnt++; if (bus.wb_stall !== 1'b0 || bus.lu_ready !== 1'b0) begin err_cnt++;
        $display("FAIL post_reset_block%0d: got stall/ready %0h/%0h, expected 0/0",
                 i, bus.wb_stall, bus.lu_ready); end
      tick();
      vec_cnt++; if (bus.rf_rd !== 5'(20 + i) || bus.rf_write_en !== 1'b1) begin err_cnt++;
        $display("FAIL post_reset_wb%0d: got rd/we %0h/%0h, expected %0h/1",
                 i, bus.rf_rd, bus.rf_write_en, 20 + i); end
    end
    bus.wb_rd = 5'd24; bus.wb_data = 32'hC0000004;
    #1;
    vec_cnt++; if (bus.wb_stall !== 1'b1 || bus.lu_ready !== 1'b1) begin err_cnt++;
      $display("FAIL post_reset_force: got stall/ready %0h/%0h, expected 1/1",
               bus.wb_stall, bus.lu_ready); end
    tick();
    bus.lu_valid = 1'b0;
    vec_cnt++; if (bus.rf_rd !== 5'd3 || bus.rf_src_lu !== 1'b1) begin err_cnt++;
      $display("FAIL post_reset_lu_write: got rd/src %0h/%0h, expected 3/1",
               bus.rf_rd, bus.rf_src_lu); end
    tick();
    bus.wb_valid = 1'b0;
    vec_cnt++; if (bus.rf_rd !== 5'd24 || bus.rf_rd_data !== 32'hC0000004) begin err_cnt++;
      $display("FAIL post_reset_held_wb: got rd/data %0h/%0h, expected 18/c0000004",
               bus.rf_rd, bus.rf_rd_data); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
    test_reset();
    test_wb_only();
    test_lu_only();
    test_x0();
    test_starvation();
    test_reset_mid_force();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
